// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline-stage registers: control-bit positions,
// default widths and the slot-occupancy state encoding.
package pipe_pkg;

  localparam int CTRL_MEMWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_HLT      = 4;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DST_W  = 4;

  // Occupancy is {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } slot_state_e;

  function automatic slot_state_e slot_state(input logic main_vld, input logic skid_vld);
    return slot_state_e'({main_vld, skid_vld});
  endfunction

endpackage

// File: rtl/pipe_stage_if.sv
// Valid/ready beat bus between two pipeline stages; the stage register sits on
// the slave side, the producer/consumer pair on the master side.
interface pipe_stage_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NDATA  = 2,
  parameter int CTRL_W = 5,
  parameter int DST_W  = DEF_DST_W
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [NDATA*DATA_W-1:0] in_data;
  logic [CTRL_W-1:0]       in_ctrl;
  logic [DST_W-1:0]        in_dst;

  logic                    out_valid;
  logic                    out_ready;
  logic [NDATA*DATA_W-1:0] out_data;
  logic [CTRL_W-1:0]       out_ctrl;
  logic [DST_W-1:0]        out_dst;

  modport master (
    output in_valid, in_data, in_ctrl, in_dst, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, out_dst
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, in_dst, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, out_dst
  );

endinterface

// File: rtl/dff.sv
// Generic D flip-flop cell with synchronous active-high clear and load enable.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_slot.sv
// One beat of storage: a valid flag that updates every cycle plus payload
// flops (data, ctrl, dst) that load only when the slot is written.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NDATA  = 2,
  parameter int CTRL_W = 5,
  parameter int DST_W  = DEF_DST_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_ld,
  input  logic                    i_vld_d,
  input  logic [NDATA*DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0]       i_ctrl,
  input  logic [DST_W-1:0]        i_dst,
  output logic                    o_vld,
  output logic [NDATA*DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0]       o_ctrl,
  output logic [DST_W-1:0]        o_dst
);

  dff #(.W(1)) u_vld (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b1),
    .i_d  (i_vld_d),
    .o_q  (o_vld)
  );

  // Payload holds through flush; only rst or a load changes it.
  dff #(.W(NDATA*DATA_W)) u_data (
    .clk  (clk),
    .rst  (rst),
    .i_en (i_ld),
    .i_d  (i_data),
    .o_q  (o_data)
  );

  dff #(.W(CTRL_W)) u_ctrl (
    .clk  (clk),
    .rst  (rst),
    .i_en (i_ld),
    .i_d  (i_ctrl),
    .o_q  (o_ctrl)
  );

  dff #(.W(DST_W)) u_dst (
    .clk  (clk),
    .rst  (rst),
    .i_en (i_ld),
    .i_d  (i_dst),
    .o_q  (o_dst)
  );

endmodule

// File: rtl/pipe_stage.sv
// Inter-stage register with valid/ready handshake, one-entry skid buffer,
// flush and a sticky halt raised when a HLT-tagged beat is delivered.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NDATA   = 2,
  parameter int CTRL_W  = 5,
  parameter int DST_W   = DEF_DST_W,
  parameter int HLT_BIT = CTRL_HLT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  output logic       halted,
  pipe_stage_if.slave bus
);

  localparam int PW = NDATA * DATA_W;

  logic              w_main_vld, w_skid_vld;
  logic [PW-1:0]     w_main_data, w_skid_data;
  logic [CTRL_W-1:0] w_main_ctrl, w_skid_ctrl;
  logic [DST_W-1:0]  w_main_dst, w_skid_dst;

  logic              w_in_fire, w_out_fire, w_out_vld, w_in_rdy;
  logic              w_main_ld, w_main_from_skid, w_skid_ld;
  logic              w_main_vld_d, w_skid_vld_d;
  logic [PW-1:0]     w_main_d_data;
  logic [CTRL_W-1:0] w_main_d_ctrl;
  logic [DST_W-1:0]  w_main_d_dst;
  slot_state_e       w_state;
  logic              r_halted;

  // in_ready depends only on registered state, never on out_ready.
  assign w_in_rdy   = !w_skid_vld && !r_halted;
  assign w_out_vld  = w_main_vld && !r_halted;
  assign w_in_fire  = bus.in_valid && w_in_rdy;
  assign w_out_fire = w_out_vld && bus.out_ready;
  assign w_state    = slot_state(w_main_vld, w_skid_vld);

  always_comb begin
    w_main_ld        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_ld        = 1'b0;
    w_main_vld_d     = w_main_vld;
    w_skid_vld_d     = w_skid_vld;
    if (flush) begin
      w_main_vld_d = 1'b0;
      w_skid_vld_d = 1'b0;
    end else begin
      case (w_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_main_ld    = 1'b1;
            w_main_vld_d = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_ld = 1'b1;
          end else if (w_in_fire) begin
            w_skid_ld    = 1'b1;
            w_skid_vld_d = 1'b1;
          end else if (w_out_fire) begin
            w_main_vld_d = 1'b0;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_main_ld        = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_vld_d     = 1'b0;
          end
        end
        default: begin
          w_main_vld_d = 1'b0;
          w_skid_vld_d = 1'b0;
        end
      endcase
    end
  end

  assign w_main_d_data = w_main_from_skid ? w_skid_data : bus.in_data;
  assign w_main_d_ctrl = w_main_from_skid ? w_skid_ctrl : bus.in_ctrl;
  assign w_main_d_dst  = w_main_from_skid ? w_skid_dst  : bus.in_dst;

  pipe_slot #(.DATA_W(DATA_W), .NDATA(NDATA), .CTRL_W(CTRL_W), .DST_W(DST_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_ld    (w_main_ld),
    .i_vld_d (w_main_vld_d),
    .i_data  (w_main_d_data),
    .i_ctrl  (w_main_d_ctrl),
    .i_dst   (w_main_d_dst),
    .o_vld   (w_main_vld),
    .o_data  (w_main_data),
    .o_ctrl  (w_main_ctrl),
    .o_dst   (w_main_dst)
  );

  pipe_slot #(.DATA_W(DATA_W), .NDATA(NDATA), .CTRL_W(CTRL_W), .DST_W(DST_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_ld    (w_skid_ld),
    .i_vld_d (w_skid_vld_d),
    .i_data  (bus.in_data),
    .i_ctrl  (bus.in_ctrl),
    .i_dst   (bus.in_dst),
    .o_vld   (w_skid_vld),
    .o_data  (w_skid_data),
    .o_ctrl  (w_skid_ctrl),
    .o_dst   (w_skid_dst)
  );

  // A HLT beat that leaves during a flush cycle was still seen downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else if (w_out_fire && w_main_ctrl[HLT_BIT]) begin
      r_halted <= 1'b1;
    end
  end

  assign halted        = r_halted;
  assign bus.in_ready  = w_in_rdy;
  assign bus.out_valid = w_out_vld;
  assign bus.out_data  = w_main_data;
  assign bus.out_ctrl  = w_out_vld ? w_main_ctrl : '0;
  assign bus.out_dst   = w_main_dst;

endmodule
